wait_merge_n: RTL and testbench

- Clocked, parametrised N-channel wait-merge (join) for the drive/free handshake fabric.
- Each channel captures its data word on a drive pulse and holds it.
- Once every enabled channel holds data, the block emits one merged drive carrying the concatenated payload. It then waits for the downstream free and returns a free pulse to every enabled channel.
- Sits between independent producer stages and a single consumer stage. Generalises the two-input merge to N channels, adds a per-channel enable mask, overflow detection and registered outputs.

---
 rtl/wait_merge_pkg.sv | 23 ++
 rtl/wm_slot.sv | 58 +++++
 rtl/wait_merge_n.sv | 193 +++++++++++++++++++
 tb/tb_wait_merge_n.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/wait_merge_pkg.sv
// -----------------------------------------------------------------------------
// wait_merge_pkg
// Shared types and helpers for the N-channel wait-merge (join) block.
//   wm_state_e : join FSM states (COLLECT, WAIT_FREE)
//   DEF_NUM_CH : default channel count
//   DEF_DATA_W : default per-channel data width
//   slice_lo() : low bit index of channel k's slice in a packed NUM_CH*W bus
// -----------------------------------------------------------------------------
package wait_merge_pkg;

    typedef enum logic [0:0] {
        COLLECT   = 1'b0,
        WAIT_FREE = 1'b1
    } wm_state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DATA_W = 32;

    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/wm_slot.sv
// -----------------------------------------------------------------------------
// wm_slot
// One channel of the wait-merge: capture register, pending flag and sticky
// overflow flag.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (clears everything)
//   drive        : channel drive pulse, data_in valid in the same cycle
//   enable       : channel participates in the current round
//   clear        : round complete, release the slot
//   data_in      : channel data word
//   held_data    : captured data word
//   pending      : slot holds data not yet released
//   overflow     : sticky, an enabled drive arrived while pending
// -----------------------------------------------------------------------------
module wm_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              drive,
    input  logic              enable,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] held_data,
    output logic              pending,
    output logic              overflow
);

    logic [DATA_W-1:0] data_reg;
    logic              pending_reg;
    logic              overflow_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_reg     <= '0;
            pending_reg  <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            // A drive on an occupied slot is lost; the held word is kept.
            // This also covers a drive coinciding with clear, because the
            // producer has not been freed yet at that point.
            if (drive && enable && pending_reg) begin
                overflow_reg <= 1'b1;
            end
            if (clear) begin
                pending_reg <= 1'b0;
            end else if (drive && enable && !pending_reg) begin
                data_reg    <= data_in;
                pending_reg <= 1'b1;
            end
        end
    end

    assign held_data = data_reg;
    assign pending   = pending_reg;
    assign overflow  = overflow_reg;

endmodule

// File: rtl/wait_merge_n.sv
// -----------------------------------------------------------------------------
// wait_merge_n
// N-channel wait-merge (join) for the drive/free handshake fabric. Each
// enabled channel captures one word on its drive pulse; once every enabled
// channel holds data a single merged drive is issued downstream. After the
// downstream free, every enabled producer receives a free pulse.
//
// Optional build macro: WAIT_MERGE_TIMEOUT_EN
//   defined   : watchdog counts WAIT_FREE cycles, o_timeout sets (sticky) when
//               the count reaches TIMEOUT_CYCLES
//   undefined : no watchdog, o_timeout tied to 0
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   i_drive      : per-channel drive pulse
//   i_data       : channel k data at [k*DATA_W +: DATA_W]
//   i_chanMask   : 1 = channel participates (sampled on entry to COLLECT)
//   i_freeNext   : downstream free pulse
//   o_free       : per-channel free pulse to producers
//   o_driveNext  : merged drive pulse to downstream
//   o_data       : merged payload, masked channels read 0
//   o_overflow   : per-channel sticky overflow
//   o_timeout    : sticky watchdog flag
// -----------------------------------------------------------------------------
module wait_merge_n
    import wait_merge_pkg::*;
#(
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int DATA_W         = DEF_DATA_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        i_drive,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic [NUM_CH-1:0]        i_chanMask,
    input  logic                     i_freeNext,
    output logic [NUM_CH-1:0]        o_free,
    output logic                     o_driveNext,
    output logic [NUM_CH*DATA_W-1:0] o_data,
    output logic [NUM_CH-1:0]        o_overflow,
    output logic                     o_timeout
);

    wm_state_e state_reg, state_next;

    logic [NUM_CH-1:0]        mask_reg;
    logic                     mask_load_reg;
    logic [NUM_CH-1:0]        eff_mask;
    logic [NUM_CH-1:0]        pending_w;
    logic [NUM_CH-1:0]        overflow_w;
    logic [NUM_CH-1:0]        ready_w;
    logic [NUM_CH*DATA_W-1:0] held_w;
    logic [NUM_CH*DATA_W-1:0] merged_w;
    logic                     fire;
    logic                     free_go;

    logic [NUM_CH-1:0]        free_reg;
    logic                     drive_next_reg;
    logic [NUM_CH*DATA_W-1:0] data_reg;

    // On the first COLLECT cycle of a round the mask register is still being
    // loaded, so drives in that cycle are judged against the incoming mask.
    assign eff_mask = (state_reg == COLLECT && mask_load_reg) ? i_chanMask : mask_reg;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
            localparam int LO = slice_lo(gi, DATA_W);

            wm_slot #(
                .DATA_W (DATA_W)
            ) u_slot (
                .clk       (clk),
                .rst       (rst),
                .drive     (i_drive[gi]),
                .enable    (eff_mask[gi]),
                .clear     (free_go),
                .data_in   (i_data[LO +: DATA_W]),
                .held_data (held_w[LO +: DATA_W]),
                .pending   (pending_w[gi]),
                .overflow  (overflow_w[gi])
            );

            // A channel is satisfied if masked off, already holding data, or
            // being driven on this very edge (the last drive completes the join).
            assign ready_w[gi] = !eff_mask[gi] || pending_w[gi] || i_drive[gi];

            // Payload as it will stand after this edge: the held word if the
            // slot was already full, otherwise the word being captured now.
            assign merged_w[LO +: DATA_W] = !eff_mask[gi] ? '0 :
                                            pending_w[gi] ? held_w[LO +: DATA_W] :
                                                            i_data[LO +: DATA_W];
        end
    endgenerate

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        fire       = 1'b0;
        free_go    = 1'b0;
        case (state_reg)
            COLLECT: begin
                // An all-zero mask would trivially satisfy the AND, so it is
                // excluded explicitly.
                if ((|eff_mask) && (&ready_w)) begin
                    fire       = 1'b1;
                    state_next = WAIT_FREE;
                end
            end
            WAIT_FREE: begin
                if (i_freeNext) begin
                    free_go    = 1'b1;
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // ------------------------------------------- mask and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_reg       <= '0;
            mask_load_reg  <= 1'b1;
            free_reg       <= '0;
            drive_next_reg <= 1'b0;
            data_reg       <= '0;
        end else begin
            if (state_reg == COLLECT && mask_load_reg) begin
                mask_reg      <= i_chanMask;
                mask_load_reg <= 1'b0;
            end
            if (free_go) begin
                mask_load_reg <= 1'b1;
            end
            drive_next_reg <= fire;
            if (fire) begin
                data_reg <= merged_w;
            end
            free_reg <= free_go ? mask_reg : '0;
        end
    end

    assign o_free      = free_reg;
    assign o_driveNext = drive_next_reg;
    assign o_data      = data_reg;
    assign o_overflow  = overflow_w;

    // ------------------------------------------------------------ watchdog
`ifdef WAIT_MERGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] wd_cnt_reg, wd_cnt_next;
    logic          timeout_reg;

    // The count equals the index of the current WAIT_FREE cycle (1 on the
    // first one), saturating at the limit, and is zero outside WAIT_FREE.
    always_comb begin
        wd_cnt_next = '0;
        if (state_next == WAIT_FREE) begin
            wd_cnt_next = (wd_cnt_reg == T_LIMIT) ? wd_cnt_reg : wd_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_reg  <= '0;
            timeout_reg <= 1'b0;
        end else begin
            wd_cnt_reg <= wd_cnt_next;
            if (state_next == WAIT_FREE && wd_cnt_next == T_LIMIT) begin
                timeout_reg <= 1'b1;
            end
        end
    end

    assign o_timeout = timeout_reg;
`else
    // The limit has no effect without the watchdog; referencing it here keeps
    // the parameter live while the flag is a constant 0.
    assign o_timeout = 1'b0 & (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_wait_merge_n.sv
// -----------------------------------------------------------------------------
// tb_wait_merge_n
// Directed, table-driven bench for wait_merge_n (NUM_CH=4, DATA_W=32,
// TIMEOUT_CYCLES=8). Each table row is one clock cycle of inputs plus the
// outputs expected right after that cycle's rising edge. A hand-written
// sequence covers the watchdog (build with WAIT_MERGE_TIMEOUT_EN to enable).
// -----------------------------------------------------------------------------
module tb_wait_merge_n;

    localparam int NC = 4;
    localparam int DW = 32;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NC-1:0]     i_drive;
    logic [NC*DW-1:0]  i_data;
    logic [NC-1:0]     i_chanMask;
    logic              i_freeNext;
    logic [NC-1:0]     o_free;
    logic              o_driveNext;
    logic [NC*DW-1:0]  o_data;
    logic [NC-1:0]     o_overflow;
    logic              o_timeout;

    int checks = 0;
    int errors = 0;

    wait_merge_n #(
        .NUM_CH         (NC),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_drive     (i_drive),
        .i_data      (i_data),
        .i_chanMask  (i_chanMask),
        .i_freeNext  (i_freeNext),
        .o_free      (o_free),
        .o_driveNext (o_driveNext),
        .o_data      (o_data),
        .o_overflow  (o_overflow),
        .o_timeout   (o_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [NC-1:0] mask;
        logic [NC-1:0] drive;
        logic [127:0]  data;
        logic          free_next;
        logic [NC-1:0] exp_free;
        logic          exp_dn;
        logic [127:0]  exp_data;
        logic [NC-1:0] exp_ovf;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] J = 32'hDEAD_BEEF;   // junk on lanes not driven
    localparam logic [127:0] Z = '0;

    function automatic logic [127:0] pk(input logic [31:0] d3, input logic [31:0] d2,
                                        input logic [31:0] d1, input logic [31:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic add(input logic r, input logic [3:0] m, input logic [3:0] dr,
                       input logic [127:0] d, input logic f, input logic [3:0] ef,
                       input logic edn, input logic [127:0] ed, input logic [3:0] eo);
        vec_t v;
        v.rst = r; v.mask = m; v.drive = dr; v.data = d; v.free_next = f;
        v.exp_free = ef; v.exp_dn = edn; v.exp_data = ed; v.exp_ovf = eo;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [3:0] m, input logic [3:0] dr,
                         input logic [127:0] d, input logic f);
        rst = r; i_chanMask = m; i_drive = dr; i_data = d; i_freeNext = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] d1, d2, d3, d4;
        logic         exp_to;

        rst = 1'b1; i_drive = '0; i_data = '0; i_chanMask = '0; i_freeNext = 1'b0;

        d1 = pk(32'h33, 32'h22, 32'h11, 32'h00);
        d2 = pk(32'hA3, 32'hA2, 32'h11, 32'hA0);
        d3 = pk(32'h0,  32'hB2, 32'h0,  32'hB0);
        d4 = pk(32'hE3, 32'hE2, 32'hE1, 32'hD0);

        //    rst  mask     drive    data                               free  exp_free exp_dn exp_data exp_ovf
        // reset state
        add(1, 4'hF, 4'h0, Z,                                      0, 4'h0, 0, Z,  4'h0);
        add(1, 4'hF, 4'h0, Z,                                      0, 4'h0, 0, Z,  4'h0);
        add(0, 4'hF, 4'h0, Z,                                      0, 4'h0, 0, Z,  4'h0);
        // out-of-order join: ch2, ch0, ch3, ch1 (free in COLLECT ignored)
        add(0, 4'hF, 4'h4, pk(J, 32'h22, J, J),                    0, 4'h0, 0, Z,  4'h0);
        add(0, 4'hF, 4'h0, Z,                                      1, 4'h0, 0, Z,  4'h0);
        add(0, 4'hF, 4'h1, pk(J, J, J, 32'h00),                    0, 4'h0, 0, Z,  4'h0);
        add(0, 4'hF, 4'h8, pk(32'h33, J, J, J),                    0, 4'h0, 0, Z,  4'h0);
        add(0, 4'hF, 4'h0, Z,                                      0, 4'h0, 0, Z,  4'h0);
        add(0, 4'hF, 4'h0, Z,                                      0, 4'h0, 0, Z,  4'h0);
        add(0, 4'hF, 4'h2, pk(J, J, 32'h11, J),                    0, 4'h0, 1, d1, 4'h0);
        add(0, 4'hF, 4'h0, Z,                                      0, 4'h0, 0, d1, 4'h0);
        // downstream free -> o_free for one cycle
        add(0, 4'hF, 4'h0, Z,                                      1, 4'hF, 0, d1, 4'h0);
        add(0, 4'hF, 4'h0, Z,                                      0, 4'h0, 0, d1, 4'h0);
        // overflow: ch1 twice, then the rest together
        add(0, 4'hF, 4'h2, pk(J, J, 32'h11, J),                    0, 4'h0, 0, d1, 4'h0);
        add(0, 4'hF, 4'h2, pk(J, J, 32'h99, J),                    0, 4'h0, 0, d1, 4'h2);
        add(0, 4'hF, 4'hD, pk(32'hA3, 32'hA2, J, 32'hA0),          0, 4'h0, 1, d2, 4'h2);
        // drive in WAIT_FREE, then drive together with free
        add(0, 4'hF, 4'h8, pk(32'h55, J, J, J),                    0, 4'h0, 0, d2, 4'hA);
        add(0, 4'hF, 4'h1, pk(J, J, J, 32'h66),                    1, 4'hF, 0, d2, 4'hB);
        // masking: mask 0101 loaded here, held even when the input changes
        add(0, 4'h5, 4'h2, pk(J, J, 32'h77, J),                    0, 4'h0, 0, d2, 4'hB);
        add(0, 4'hF, 4'h3, pk(J, J, 32'h78, 32'hB0),               0, 4'h0, 0, d2, 4'hB);
        add(0, 4'hF, 4'hC, pk(32'hBAD3, 32'hB2, J, J),             0, 4'h0, 1, d3, 4'hB);
        add(0, 4'hF, 4'h0, Z,                                      1, 4'h5, 0, d3, 4'hB);
        add(0, 4'hF, 4'h0, Z,                                      0, 4'h0, 0, d3, 4'hB);
        // reset mid-round with ch0 pending
        add(0, 4'hF, 4'h1, pk(J, J, J, 32'hC0),                    0, 4'h0, 0, d3, 4'hB);
        add(1, 4'hF, 4'h0, Z,                                      0, 4'h0, 0, Z,  4'h0);
        add(0, 4'hF, 4'hE, pk(32'hE3, 32'hE2, 32'hE1, J),          0, 4'h0, 0, Z,  4'h0);
        add(0, 4'hF, 4'h0, Z,                                      0, 4'h0, 0, Z,  4'h0);
        add(0, 4'hF, 4'h0, Z,                                      0, 4'h0, 0, Z,  4'h0);
        // ch0 finally arrives: earlier captures survive
        add(0, 4'hF, 4'h1, pk(J, J, J, 32'hD0),                    0, 4'h0, 1, d4, 4'h0);
        add(0, 4'hF, 4'h0, Z,                                      1, 4'hF, 0, d4, 4'h0);
        // all-zero mask never fires
        add(0, 4'h0, 4'h0, Z,                                      0, 4'h0, 0, d4, 4'h0);
        add(0, 4'hF, 4'hF, pk(32'h1, 32'h2, 32'h3, 32'h4),         0, 4'h0, 0, d4, 4'h0);
        add(0, 4'hF, 4'h0, Z,                                      1, 4'h0, 0, d4, 4'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].mask, vecs[i].drive, vecs[i].data, vecs[i].free_next);
            $display("vec %0d: rst=%b mask=%h drive=%h free=%b -> o_free=%h dn=%b ovf=%h data=%h",
                     i, vecs[i].rst, vecs[i].mask, vecs[i].drive, vecs[i].free_next,
                     o_free, o_driveNext, o_overflow, o_data);
            chk($sformatf("vec%0d o_free", i),      128'(o_free),      128'(vecs[i].exp_free));
            chk($sformatf("vec%0d o_driveNext", i), 128'(o_driveNext), 128'(vecs[i].exp_dn));
            chk($sformatf("vec%0d o_data", i),      o_data,            vecs[i].exp_data);
            chk($sformatf("vec%0d o_overflow", i),  128'(o_overflow),  128'(vecs[i].exp_ovf));
        end

        // ---- watchdog sequence: fire, then withhold the free for 12 cycles
        apply(1, 4'hF, 4'h0, Z, 0);
        chk("wd reset o_timeout", 128'(o_timeout), 128'(0));
        apply(0, 4'hF, 4'hF, pk(32'h4, 32'h3, 32'h2, 32'h1), 0);
        $display("wd fire: dn=%b timeout=%b", o_driveNext, o_timeout);
        chk("wd fire o_driveNext", 128'(o_driveNext), 128'(1));
        for (int j = 1; j <= 12; j++) begin
            if (j > 1) apply(0, 4'hF, 4'h0, Z, 0);
`ifdef WAIT_MERGE_TIMEOUT_EN
            exp_to = (j >= TO);
`else
            exp_to = 1'b0;
`endif
            $display("wd wait cycle %0d: timeout=%b", j, o_timeout);
            chk($sformatf("wd cycle%0d o_timeout", j), 128'(o_timeout), 128'(exp_to));
        end
        apply(0, 4'hF, 4'h0, Z, 1);
        $display("wd free: o_free=%h timeout=%b", o_free, o_timeout);
        chk("wd free o_free", 128'(o_free), 128'(4'hF));
        chk("wd free o_timeout", 128'(o_timeout), 128'(exp_to));
        apply(0, 4'hF, 4'h0, Z, 0);
        chk("wd after o_timeout", 128'(o_timeout), 128'(exp_to));
        chk("wd after o_data", o_data, pk(32'h4, 32'h3, 32'h2, 32'h1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
